// File: rtl/spraid_spi_chan.sv
// SPI mode-0 master channel: one request in, one right-justified response out, optional CS hold.
// Optional feature macro SPRAID_LOOPBACK_EN adds cfg_loopback (receive path taps spi_mosi).
module spraid_spi_chan (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_len,
  input  logic        req_hold_cs,
  input  logic [7:0]  clk_div,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        spi_clk,
  output logic        spi_cs,
  output logic        spi_mosi,
`ifdef SPRAID_LOOPBACK_EN
  input  logic        cfg_loopback,
`endif
  input  logic        spi_miso
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SCK_HI = 3'd2,
    SCK_LO = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state_r;
  logic [7:0]  div_r;
  logic [7:0]  cnt_r;
  logic [4:0]  bits_r;
  logic [4:0]  last_bit_r;
  logic [31:0] tx_r;
  logic [31:0] rx_r;
  logic        hold_r;
  logic        cs_r;
  logic        sck_r;
  logic        mosi_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_data_r;
  logic        ready_r;
  logic        busy_r;
  logic        rx_bit_s;
  logic        cnt_done_s;

  // Receive bit source: external pin, or the driven MOSI when looped back.
  always_comb begin
`ifdef SPRAID_LOOPBACK_EN
    if (cfg_loopback) begin
      rx_bit_s = mosi_r;
    end else begin
      rx_bit_s = spi_miso;
    end
`else
    rx_bit_s = spi_miso;
`endif
  end

  // End of a D-cycle phase; cnt_r runs 0..div_r so D=256 fits in 8 bits.
  always_comb begin
    cnt_done_s = (cnt_r == div_r);
  end

  // Transfer sequencer with all pin and response registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r     <= IDLE;
      div_r       <= 8'd0;
      cnt_r       <= 8'd0;
      bits_r      <= 5'd0;
      last_bit_r  <= 5'd0;
      tx_r        <= 32'd0;
      rx_r        <= 32'd0;
      hold_r      <= 1'b0;
      cs_r        <= 1'b1;
      sck_r       <= 1'b0;
      mosi_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 32'd0;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rsp_valid_r <= 1'b0;
          sck_r       <= 1'b0;
          mosi_r      <= 1'b0;
          if (req_valid && ready_r) begin
            tx_r       <= req_data;
            rx_r       <= 32'd0;
            div_r      <= clk_div;
            last_bit_r <= {req_len, 3'b111};
            hold_r     <= req_hold_cs;
            bits_r     <= 5'd0;
            cnt_r      <= 8'd0;
            cs_r       <= 1'b0;
            mosi_r     <= req_data[31];
            ready_r    <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_done_s) begin
            cnt_r   <= 8'd0;
            sck_r   <= 1'b1;
            rx_r    <= {rx_r[30:0], rx_bit_s};
            state_r <= SCK_HI;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        SCK_HI: begin
          if (cnt_done_s) begin
            cnt_r   <= 8'd0;
            sck_r   <= 1'b0;
            tx_r    <= tx_r << 5'd1;
            mosi_r  <= tx_r[30];
            state_r <= SCK_LO;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        SCK_LO: begin
          if (cnt_done_s) begin
            cnt_r <= 8'd0;
            if (bits_r == last_bit_r) begin
              rsp_valid_r <= 1'b1;
              rsp_data_r  <= rx_r;
              cs_r        <= ~hold_r;
              mosi_r      <= 1'b0;
              state_r     <= DONE;
            end else begin
              bits_r  <= bits_r + 5'd1;
              sck_r   <= 1'b1;
              rx_r    <= {rx_r[30:0], rx_bit_s};
              state_r <= SCK_HI;
            end
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        DONE: begin
          rsp_valid_r <= 1'b0;
          ready_r     <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          rsp_valid_r <= 1'b0;
          sck_r       <= 1'b0;
          mosi_r      <= 1'b0;
          cs_r        <= 1'b1;
          ready_r     <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = ready_r;
  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign spi_clk   = sck_r;
  assign spi_cs    = cs_r;
  assign spi_mosi  = mosi_r;

endmodule

// File: tb/tb_spraid_spi_chan.sv
// Scoreboard bench for spraid_spi_chan: driver queues expected response data and cycle,
// monitor pops on rsp_valid; a simple mode-0 slave model feeds spi_miso.
module tb_spraid_spi_chan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_data;
  logic [1:0]  req_len;
  logic        req_hold_cs;
  logic [7:0]  clk_div;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;
  logic        spi_clk;
  logic        spi_cs;
  logic        spi_mosi;
  logic        spi_miso;
`ifdef SPRAID_LOOPBACK_EN
  logic        cfg_loopback;
`endif

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          fcnt = 0;
  int          base = 0;
  int          cs_bad = 0;
  bit          cs_watch = 1'b0;
  int          watch_until = 0;
  logic        clk_prev = 1'b0;
  logic [31:0] mosi_cap = 32'd0;
  logic [31:0] slv_data = 32'd0;
  logic [31:0] slv_sh;

  spraid_spi_chan dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .req_len     (req_len),
    .req_hold_cs (req_hold_cs),
    .clk_div     (clk_div),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .busy        (busy),
    .spi_clk     (spi_clk),
    .spi_cs      (spi_cs),
    .spi_mosi    (spi_mosi),
`ifdef SPRAID_LOOPBACK_EN
    .cfg_loopback(cfg_loopback),
`endif
    .spi_miso    (spi_miso)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave presents slv_data MSB-first, advancing on each spi_clk fall.
  always_comb slv_sh = slv_data << (fcnt - base);
  assign spi_miso = slv_sh[31];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops, MOSI capture on rising SCK, CS-hold watch.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", rsp_data, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (cs_watch && cyc < watch_until && spi_cs !== 1'b0) cs_bad++;
      if (spi_clk === 1'b1 && clk_prev === 1'b0) mosi_cap = {mosi_cap[30:0], spi_mosi};
      if (spi_clk === 1'b0 && clk_prev === 1'b1) fcnt++;
      clk_prev = spi_clk;
    end
  end

  task automatic send(input logic [31:0] d, input logic [1:0] l, input logic h,
                      input logic [7:0] dv, input logic [31:0] slv,
                      input logic [31:0] exp_d, input int t, input bit push,
                      output int acc0);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(req_ready), 32'd1);
    slv_data    = slv;
    base        = fcnt;
    req_data    = d;
    req_len     = l;
    req_hold_cs = h;
    clk_div     = dv;
    req_valid   = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc0      = cyc - 1;
    if (push) begin
      e.data = exp_d;
      e.cyc  = acc0 + t;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 32'(busy), 32'd0);
  endtask

  initial begin
    int acc;
    int cs_bad0;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_data    = 32'd0;
    req_len     = 2'd0;
    req_hold_cs = 1'b0;
    clk_div     = 8'd0;
`ifdef SPRAID_LOOPBACK_EN
    cfg_loopback = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_cs", 32'(spi_cs), 32'd1);
    chk("rst_sck", 32'(spi_clk), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // D=1, one byte, MISO stuck high
    send(32'hA500_0000, 2'd0, 1'b0, 8'd0, 32'hFFFF_FFFF, 32'h0000_00FF, 18, 1'b1, acc);
    wait_idle(200);
    chk("mosi_a5", 32'(mosi_cap[7:0]), 32'h0000_00A5);
    chk("cs_release", 32'(spi_cs), 32'd1);

    // Inputs scrambled after acceptance must not matter
    send(32'h3C96_0000, 2'd1, 1'b0, 8'd2, 32'h5A3C_0000, 32'h0000_5A3C, 100, 1'b1, acc);
    req_data    = 32'hFFFF_FFFF;
    clk_div     = 8'd0;
    req_len     = 2'd3;
    req_hold_cs = 1'b1;
    wait_idle(500);
    chk("mosi_latched", 32'(mosi_cap[15:0]), 32'h0000_3C96);
    chk("cs_hold_latched", 32'(spi_cs), 32'd1);

    // CS held low across two transfers
    cs_bad0 = cs_bad;
    send(32'h8100_0000, 2'd0, 1'b1, 8'd1, 32'hC300_0000, 32'h0000_00C3, 35, 1'b1, acc);
    watch_until = 32'h7FFF_FFFF;
    cs_watch    = 1'b1;
    wait_idle(500);
    chk("cs_held_idle", 32'(spi_cs), 32'd0);
    send(32'h1234_5600, 2'd2, 1'b0, 8'd0, 32'hABCD_EF00, 32'h00AB_CDEF, 50, 1'b1, acc);
    watch_until = acc + 50;
    wait_idle(500);
    cs_watch = 1'b0;
    chk("cs_low_window", 32'(cs_bad), 32'(cs_bad0));
    chk("cs_after_hold", 32'(spi_cs), 32'd1);
    chk("mosi_24", mosi_cap & 32'h00FF_FFFF, 32'h0012_3456);

    // Reset during the 5th bit of a 16-bit transfer
    send(32'hFFFF_0000, 2'd1, 1'b0, 8'd0, 32'hFFFF_FFFF, 32'd0, 0, 1'b0, acc);
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("bit5_sck_high", 32'(spi_clk), 32'd1);
    chk("bit5_cs_low", 32'(spi_cs), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_cs", 32'(spi_cs), 32'd1);
    chk("abort_rsp_data", rsp_data, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sck", 32'(spi_clk), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_idle_busy", 32'(busy), 32'd0);

    // Full 32-bit word, D=4
    send(32'hCAFE_F00D, 2'd3, 1'b0, 8'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 261, 1'b1, acc);
    wait_idle(500);
    chk("mosi_32", mosi_cap, 32'hCAFE_F00D);

    // Largest divider, D=256
    send(32'h0100_0000, 2'd0, 1'b0, 8'hFF, 32'h6E00_0000, 32'h0000_006E, 4353, 1'b1, acc);
    wait_idle(5000);
    chk("mosi_div_ff", 32'(mosi_cap[7:0]), 32'h0000_0001);

`ifdef SPRAID_LOOPBACK_EN
    cfg_loopback = 1'b1;
    send(32'hDEAD_BEEF, 2'd3, 1'b0, 8'd3, 32'd0, 32'hDEAD_BEEF, 261, 1'b1, acc);
    wait_idle(500);
    cfg_loopback = 1'b0;
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
